// File: rtl/tas_serial_src.sv
// tas_serial_src: byte-to-serial source for the tas temperature averager.
// Bytes arrive over a valid/ready handshake, are buffered in a DEPTH-entry
// FIFO, and leave one bit per BIT_DIV clocks with data_ena framing each byte,
// followed by GAP_BITS idle bit periods.
//
// Ports:
//   clk_50       system clock, rising edge
//   reset        synchronous active-high reset
//   byte_in      byte to transmit
//   byte_valid   byte_in is valid
//   byte_ready   FIFO can accept a byte (combinational)
//   serial_data  serial bit to tas (registered)
//   data_ena     high while a byte's bits are on serial_data (registered)
//   fifo_count   bytes currently held in the FIFO
//   busy         state machine active or FIFO non-empty
//
// Build option: define SERTX_MSB_FIRST_EN to shift bits out MSB first;
// by default bits leave LSB first. Timing is identical in both builds.
module tas_serial_src #(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned BIT_DIV  = 25,
   parameter int unsigned GAP_BITS = 2
) (
   input  logic                   clk_50,
   input  logic                   reset,
   input  logic [7:0]             byte_in,
   input  logic                   byte_valid,
   output logic                   byte_ready,
   output logic                   serial_data,
   output logic                   data_ena,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy
);

   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned GAP_CYC = GAP_BITS * BIT_DIV;
   localparam int unsigned TMR_W   = $clog2(GAP_CYC + 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

   state_t           state;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [7:0]       shreg;
   logic [7:0]       shreg_nxt;
   logic [2:0]       bit_cnt;
   logic [TMR_W-1:0] timer;
   logic [7:0]       head;
   logic             head_bit;
   logic             nxt_bit;
   logic             push;
   logic             pop;

   // Handshake and status decode
   assign byte_ready = !reset && (fifo_count != CNT_W'(DEPTH));
   assign push       = byte_valid && byte_ready;
   assign pop        = (state == LOAD) && (fifo_count != '0);
   assign busy       = (state != IDLE) || (fifo_count != '0);
   assign head       = mem[rd_ptr];

   // Bit order selection. The shift is a rotate so every register bit stays
   // live; after eight shifts the register content is simply discarded.
`ifdef SERTX_MSB_FIRST_EN
   assign shreg_nxt = {shreg[6:0], shreg[7]};
   assign head_bit  = head[7];
   assign nxt_bit   = shreg_nxt[7];
`else
   assign shreg_nxt = {shreg[0], shreg[7:1]};
   assign head_bit  = head[0];
   assign nxt_bit   = shreg_nxt[0];
`endif

   // FIFO storage; contents need no reset since pointers define validity
   always_ff @(posedge clk_50) begin
      if (push) begin
         mem[wr_ptr] <= byte_in;
      end
   end

   // FIFO pointers/count plus the transmit state machine
   always_ff @(posedge clk_50) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fifo_count  <= '0;
         shreg       <= '0;
         bit_cnt     <= '0;
         timer       <= '0;
         serial_data <= 1'b0;
         data_ena    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase

         case (state)
            IDLE: begin
               data_ena    <= 1'b0;
               serial_data <= 1'b0;
               if (fifo_count != '0) begin
                  state <= LOAD;
               end
            end
            // Outputs are registered, so the first bit is driven straight
            // from the FIFO head as the shift register is loaded.
            LOAD: begin
               shreg       <= head;
               bit_cnt     <= '0;
               timer       <= TMR_W'(BIT_DIV - 1);
               data_ena    <= 1'b1;
               serial_data <= head_bit;
               state       <= SHIFT;
            end
            SHIFT: begin
               if (timer == '0) begin
                  shreg   <= shreg_nxt;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     timer       <= TMR_W'(GAP_CYC - 1);
                     data_ena    <= 1'b0;
                     serial_data <= 1'b0;
                     state       <= GAP;
                  end else begin
                     timer       <= TMR_W'(BIT_DIV - 1);
                     serial_data <= nxt_bit;
                  end
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            GAP: begin
               data_ena    <= 1'b0;
               serial_data <= 1'b0;
               if (timer == '0) begin
                  state <= IDLE;
               end else begin
                  timer <= timer - TMR_W'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tas_serial_src.sv
// tb_tas_serial_src: scoreboard bench for tas_serial_src.
// Two instances: default parameters, and the minimum (DEPTH=2, BIT_DIV=2,
// GAP_BITS=1). Accepted bytes are queued as expectations; a per-instance
// monitor rebuilds each serial byte from data_ena/serial_data and checks
// bit hold time, byte length, gap length and back-to-back spacing.
module tb_tas_serial_src;

   localparam int NI  = 2;
   localparam int QN  = 32;
   localparam int BD0 = 25;
   localparam int GB0 = 2;

   logic clk_50 = 1'b0;
   always #10 clk_50 = ~clk_50;

   logic        reset       [NI];
   logic [7:0]  byte_in     [NI];
   logic        byte_valid  [NI];
   logic        byte_ready  [NI];
   logic        serial_data [NI];
   logic        data_ena    [NI];
   logic        busy        [NI];
   logic [31:0] fcnt        [NI];
   logic        chk_sp      [NI];

   logic [7:0]  exp_mem [NI][QN];
   int          exp_wr  [NI];
   int          exp_rd  [NI];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int DP = (g == 0) ? 8 : 2;
      localparam int BD = (g == 0) ? BD0 : 2;
      localparam int GB = (g == 0) ? GB0 : 1;

      logic [$clog2(DP):0] fc;

      tas_serial_src #(.DEPTH(DP), .BIT_DIV(BD), .GAP_BITS(GB)) u_dut (
         .clk_50      (clk_50),
         .reset       (reset[g]),
         .byte_in     (byte_in[g]),
         .byte_valid  (byte_valid[g]),
         .byte_ready  (byte_ready[g]),
         .serial_data (serial_data[g]),
         .data_ena    (data_ena[g]),
         .fifo_count  (fc),
         .busy        (busy[g])
      );
      assign fcnt[g] = 32'(fc);

      int         cyc = 0;
      int         hi = 0;
      int         lo = 0;
      int         last_rise = 0;
      logic       prev_ena = 1'b0;
      logic       have_rise = 1'b0;
      logic       have_fall = 1'b0;
      logic       cur = 1'b0;
      logic       bits [8];
      logic [7:0] got;

      // Monitor: rebuild bytes and check framing on every falling clock edge
      always @(negedge clk_50) begin : mon
         if (reset[g]) begin
            prev_ena  = 1'b0;
            hi        = 0;
            lo        = 0;
            have_rise = 1'b0;
            have_fall = 1'b0;
         end else begin
            if (data_ena[g]) begin
               if (!prev_ena) begin
                  if (have_fall)
                     check($sformatf("gap_min%0d", g), 32'(lo >= GB * BD + 2), 1);
                  if (have_rise && chk_sp[g])
                     check($sformatf("rise_spacing%0d", g), cyc - last_rise, (8 + GB) * BD + 2);
                  last_rise = cyc;
                  have_rise = 1'b1;
                  hi        = 0;
               end
               if (hi % BD == 0) begin
                  cur = serial_data[g];
                  if (hi / BD < 8) bits[hi / BD] = cur;
               end else begin
                  check($sformatf("bit_hold%0d", g), serial_data[g], cur);
               end
               hi++;
            end else begin
               if (prev_ena) begin
                  check($sformatf("ena_len%0d", g), hi, 8 * BD);
                  for (int i = 0; i < 8; i++) begin
`ifdef SERTX_MSB_FIRST_EN
                     got[7 - i] = bits[i];
`else
                     got[i] = bits[i];
`endif
                  end
                  check($sformatf("byte_expected%0d", g), 32'(exp_wr[g] != exp_rd[g]), 1);
                  if (exp_wr[g] != exp_rd[g]) begin
                     check($sformatf("byte%0d", g), got, exp_mem[g][exp_rd[g] % QN]);
                     exp_rd[g]++;
                  end
                  have_fall = 1'b1;
                  lo        = 0;
               end
               check($sformatf("idle_zero%0d", g), serial_data[g], 0);
               lo++;
            end
            prev_ena = data_ena[g];
         end
         cyc++;
      end
   end

   // Present one byte for one cycle; called and returns on a falling edge
   task automatic push(input int g, input logic [7:0] b);
      logic acc;
      byte_in[g]    = b;
      byte_valid[g] = 1'b1;
      acc           = byte_ready[g];
      if (acc) begin
         exp_mem[g][exp_wr[g] % QN] = b;
         exp_wr[g]++;
      end
      @(negedge clk_50);
      byte_valid[g] = 1'b0;
   endtask

   task automatic wait_ena(input int g, input logic lvl, input int budget);
      int n = 0;
      while (data_ena[g] !== lvl && n < budget) begin
         @(negedge clk_50);
         n++;
      end
      check($sformatf("wait_ena%0d", g), data_ena[g], lvl);
   endtask

   task automatic wait_idle(input int g, input int budget);
      int n = 0;
      while ((busy[g] !== 1'b0 || data_ena[g] !== 1'b0) && n < budget) begin
         @(negedge clk_50);
         n++;
      end
      check($sformatf("idle_reached%0d", g), busy[g], 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

   logic [7:0] fill [10];
   int         seen;

   initial begin
      fill = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F, 8'hE1};
      for (int g = 0; g < NI; g++) begin
         reset[g]      = 1'b1;
         byte_in[g]    = 8'h00;
         byte_valid[g] = 1'b0;
         chk_sp[g]     = 1'b0;
         exp_wr[g]     = 0;
         exp_rd[g]     = 0;
      end
      repeat (3) @(negedge clk_50);

      // Reset state
      check("rst_ena", data_ena[0], 0);
      check("rst_sd", serial_data[0], 0);
      check("rst_cnt", fcnt[0], 0);
      check("rst_busy", busy[0], 0);
      check("rst_ready", byte_ready[0], 0);
      check("rst_ready1", byte_ready[1], 0);
      reset[0] = 1'b0;
      reset[1] = 1'b0;
      @(negedge clk_50);
      check("ready_after_rst", byte_ready[0], 1);

      // Single byte: latency, framing, busy after gap
      push(0, 8'hA5);
      check("lat_cnt", fcnt[0], 1);
      check("lat_e0", data_ena[0], 0);
      @(negedge clk_50);
      check("lat_e1", data_ena[0], 0);
      @(negedge clk_50);
      check("lat_e2", data_ena[0], 1);
      check("lat_pop", fcnt[0], 0);
      wait_ena(0, 1'b0, 300);
      repeat (GB0 * BD0 - 1) @(negedge clk_50);
      check("busy_in_gap", busy[0], 1);
      @(negedge clk_50);
      check("busy_after_gap", busy[0], 0);

      // Back-to-back: third push coincides with the first LOAD pop
      push(0, 8'h01);
      check("b2b_cnt0", fcnt[0], 1);
      push(0, 8'h80);
      check("b2b_cnt1", fcnt[0], 2);
      push(0, 8'hFF);
      check("b2b_cnt2", fcnt[0], 2);
      @(negedge clk_50);
      chk_sp[0] = 1'b1;
      wait_ena(0, 1'b0, 300);
      wait_ena(0, 1'b1, 100);
      check("b2b_pop1", fcnt[0], 1);
      wait_ena(0, 1'b0, 300);
      wait_ena(0, 1'b1, 100);
      check("b2b_pop2", fcnt[0], 0);
      wait_idle(0, 400);
      chk_sp[0] = 1'b0;

      // Full FIFO: ten bytes offered one per cycle, the tenth is refused
      for (int i = 0; i < 10; i++) begin
         push(0, fill[i]);
         if (i == 8) begin
            check("full_cnt", fcnt[0], 8);
            check("full_ready", byte_ready[0], 0);
         end
      end
      check("full_hold_cnt", fcnt[0], 8);
      chk_sp[0] = 1'b1;
      wait_idle(0, 9 * 252 + 300);
      chk_sp[0] = 1'b0;
      check("full_all_out", exp_wr[0] - exp_rd[0], 0);

      // Reset during bit 3 of 0x3C with another byte still queued
      push(0, 8'h3C);
      push(0, 8'h77);
      wait_ena(0, 1'b1, 10);
      repeat (80) @(negedge clk_50);
      reset[0]  = 1'b1;
      exp_wr[0] = exp_rd[0];
      @(negedge clk_50);
      check("mid_rst_ena", data_ena[0], 0);
      check("mid_rst_cnt", fcnt[0], 0);
      check("mid_rst_busy", busy[0], 0);
      check("mid_rst_ready", byte_ready[0], 0);
      @(negedge clk_50);
      reset[0] = 1'b0;
      @(negedge clk_50);
      check("post_rst_ready", byte_ready[0], 1);
      seen = 0;
      repeat (300) begin
         @(negedge clk_50);
         if (data_ena[0] !== 1'b0) seen++;
      end
      check("no_resume", seen, 0);
      push(0, 8'h5A);
      wait_ena(0, 1'b1, 10);
      wait_idle(0, 400);
      check("fresh_done", exp_wr[0] - exp_rd[0], 0);

      // Minimum parameters: 0xC3 twice, 20-cycle spacing
      push(1, 8'hC3);
      push(1, 8'hC3);
      check("min_cnt", fcnt[1], 2);
      wait_ena(1, 1'b1, 10);
      @(negedge clk_50);
      chk_sp[1] = 1'b1;
      wait_idle(1, 200);
      chk_sp[1] = 1'b0;
      check("min_all_out", exp_wr[1] - exp_rd[1], 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
